// File: rtl/wb_decompressor.sv
// Slave endpoint of the compressed wishbone link: rebuilds the two-beat header
// plus data beats into classic wishbone master cycles and returns ack/err/data.
module wb_decompressor #(
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] cw_io_i,
  output logic [DW-1:0] cw_io_o,
  input  logic          cw_req,
  input  logic          cw_dir,
  output logic          cw_ack,
  output logic          cw_err,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_o_dat,
  input  logic [DW-1:0] wb_i_dat,
  output logic          wb_we,
  output logic [1:0]    wb_sel,
  input  logic          wb_ack,
  input  logic          wb_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WAIT, S_BUS, S_ACK, S_ERR, S_END
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   base_lo;
  logic [7:0]    base_hi;
  logic [2:0]    beat;
  logic [2:0]    last_beat;
  logic [TW-1:0] tcnt;
  logic [23:0]   cur_adr;
  logic          timed_out;
  logic          more;

  // Burst beats walk consecutive addresses and wrap at the 24-bit boundary.
  assign cur_adr   = {base_hi, base_lo} + 24'(beat);
  assign wb_adr    = cur_adr[AW-1:0];
  assign timed_out = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));
  assign more      = (beat != last_beat);

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cw_req) state_nxt = S_HDR;
      S_HDR:  state_nxt = S_WAIT;
      S_WAIT: if (!wb_we || cw_dir) state_nxt = S_BUS;
      S_BUS: begin
        if (wb_err)         state_nxt = S_ERR;
        else if (wb_ack)    state_nxt = S_ACK;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_ACK:  state_nxt = more ? S_WAIT : S_END;
      S_ERR:  state_nxt = S_END;
      S_END:  if (!cw_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Dropping the request mid-transaction abandons it without any response.
    if (!cw_req && state != S_IDLE && state != S_END) state_nxt = S_IDLE;
  end

  always_comb begin
    cw_ack = 1'b0;
    cw_err = 1'b0;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    case (state)
      S_BUS: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
      end
      S_ACK: begin
        cw_ack = 1'b1;
        wb_cyc = more;
      end
      S_ERR:  cw_err = 1'b1;
      S_WAIT: wb_cyc = (beat != 3'd0);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      base_lo   <= '0;
      base_hi   <= '0;
      beat      <= '0;
      last_beat <= '0;
      tcnt      <= '0;
      wb_we     <= 1'b0;
      wb_sel    <= '0;
      wb_o_dat  <= '0;
      cw_io_o   <= '0;
    end else begin
      tcnt <= (state == S_BUS) ? tcnt + 1'b1 : '0;
      case (state)
        S_IDLE: if (cw_req) base_lo <= cw_io_i[15:0];
        S_HDR: begin
          base_hi   <= cw_io_i[7:0];
          wb_we     <= cw_io_i[8];
          wb_sel    <= cw_io_i[10:9];
          last_beat <= cw_io_i[12] ? 3'd7 : (cw_io_i[11] ? 3'd3 : 3'd0);
          beat      <= '0;
        end
        S_WAIT: if (wb_we && cw_dir) wb_o_dat <= cw_io_i;
        // An ack coinciding with an abort or an err is not captured.
        S_BUS:  if (cw_req && wb_ack && !wb_err && !wb_we) cw_io_o <= wb_i_dat;
        S_ACK:  beat <= beat + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decompressor.sv
// Self-checking bench for wb_decompressor: a compressor-side driver and a
// wishbone slave model exercise reads, bursts, errors, timeout, abort and reset.
module tb_wb_decompressor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cw_io_i;
  logic        cw_req, cw_dir;
  logic [15:0] wb_i_dat;
  logic        wb_ack, wb_err;

  logic [15:0] cw_io_o, wb_o_dat;
  logic        cw_ack, cw_err, wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [1:0]  wb_sel;

  logic [15:0] t0_cw_io_o, t0_wb_o_dat;
  logic        t0_cw_ack, t0_cw_err, t0_wb_cyc, t0_wb_stb, t0_wb_we;
  logic [23:0] t0_wb_adr;
  logic [1:0]  t0_wb_sel;

  logic [62:0] all_out;
  logic [62:0] t0_all_out;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign all_out    = {cw_io_o, cw_ack, cw_err, wb_cyc, wb_stb, wb_adr, wb_o_dat, wb_we, wb_sel};
  assign t0_all_out = {t0_cw_io_o, t0_cw_ack, t0_cw_err, t0_wb_cyc, t0_wb_stb, t0_wb_adr,
                       t0_wb_o_dat, t0_wb_we, t0_wb_sel};

  wb_decompressor #(.AW(24), .DW(16), .TIMEOUT(255)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .cw_io_i(cw_io_i), .cw_io_o(cw_io_o),
    .cw_req(cw_req), .cw_dir(cw_dir), .cw_ack(cw_ack), .cw_err(cw_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_o_dat(wb_o_dat),
    .wb_i_dat(wb_i_dat), .wb_we(wb_we), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  // Second instance with the timeout disabled shares every input.
  wb_decompressor #(.AW(24), .DW(16), .TIMEOUT(0)) u_dut_nto (
    .i_clk(clk), .i_rst(rst_n), .cw_io_i(cw_io_i), .cw_io_o(t0_cw_io_o),
    .cw_req(cw_req), .cw_dir(cw_dir), .cw_ack(t0_cw_ack), .cw_err(t0_cw_err),
    .wb_cyc(t0_wb_cyc), .wb_stb(t0_wb_stb), .wb_adr(t0_wb_adr), .wb_o_dat(t0_wb_o_dat),
    .wb_i_dat(wb_i_dat), .wb_we(t0_wb_we), .wb_sel(t0_wb_sel), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  task automatic test_reset();
    rst_n = 1'b0; cw_req = 1'b1; cw_dir = 1'b1; cw_io_i = 16'hFFFF;
    wb_ack = 1'b0; wb_err = 1'b0; wb_i_dat = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== 63'h0) $display("FAIL reset_outputs: got %0h expected 0", all_out);
    else passes++;
    checks++;
    if (t0_all_out !== 63'h0) $display("FAIL reset_outputs_nto: got %0h expected 0", t0_all_out);
    else passes++;
    cw_req = 1'b0; cw_dir = 1'b0; cw_io_i = 16'h0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    @(negedge clk); cw_req = 1'b1; cw_dir = 1'b0; cw_io_i = 16'h3456;
    @(negedge clk);
    checks++;
    if (wb_stb !== 1'b0) $display("FAIL sr_hdr_stb: got %0b expected 0", wb_stb); else passes++;
    cw_io_i = {3'b000, 1'b0, 1'b0, 2'b11, 1'b0, 8'h12};
    @(negedge clk);
    checks++;
    if (wb_stb !== 1'b0) $display("FAIL sr_wait_stb: got %0b expected 0", wb_stb); else passes++;
    @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr} !== {1'b1, 1'b1, 1'b0, 2'b11, 24'h123456})
      $display("FAIL sr_bus: got %0h expected %0h", {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr},
               {1'b1, 1'b1, 1'b0, 2'b11, 24'h123456});
    else passes++;
    wb_ack = 1'b1; wb_i_dat = 16'hBEEF;
    @(negedge clk); wb_ack = 1'b0; wb_i_dat = 16'h0;
    checks++;
    if ({cw_ack, cw_err, wb_stb, wb_cyc} !== 4'b1000)
      $display("FAIL sr_ack: got %0b expected 1000", {cw_ack, cw_err, wb_stb, wb_cyc});
    else passes++;
    checks++;
    if (cw_io_o !== 16'hBEEF) $display("FAIL sr_data: got %0h expected beef", cw_io_o); else passes++;
    @(negedge clk);
    checks++;
    if ({cw_ack, wb_cyc, wb_stb} !== 3'b000)
      $display("FAIL sr_end: got %0b expected 000", {cw_ack, wb_cyc, wb_stb});
    else passes++;
    cw_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cw_io_o !== 16'hBEEF) $display("FAIL sr_hold: got %0h expected beef", cw_io_o); else passes++;
  endtask

  // Drives one transaction and models both the compressor and the slave.
  task automatic run_txn(input logic [23:0] adr, input logic we, input logic [1:0] sel,
                         input logic b4, input logic b8, input int err_beat, input int abort_beat,
                         input int max_wait, input int dir_stall, input bit seq);
    int n, exp_acks, exp_errs, acks, errs, wait_left, stall, cyc;
    int exp_adr;
    logic [15:0] wd[8];
    logic [15:0] rd[8];
    bit done, in_beat, both, aborted;
    n = b8 ? 8 : (b4 ? 4 : 1);
    exp_errs = (err_beat >= 0 && err_beat < n) ? 1 : 0;
    exp_acks = (exp_errs == 1) ? err_beat : n;
    if (abort_beat >= 0 && abort_beat < n) begin
      exp_acks = abort_beat;
      exp_errs = 0;
    end
    for (int k = 0; k < 8; k++) begin
      wd[k] = seq ? 16'(k + 1) : 16'($urandom);
      rd[k] = 16'($urandom);
    end
    acks = 0; errs = 0; done = 0; in_beat = 0; both = 0; aborted = 0; wait_left = 0;
    stall = we ? dir_stall : 0;
    @(negedge clk); cw_req = 1'b1; cw_dir = 1'b0; cw_io_i = adr[15:0];
    @(negedge clk); cw_io_i = {3'($urandom), b8, b4, sel, we, adr[23:16]};
    @(negedge clk); cw_io_i = wd[0]; cw_dir = we && (stall == 0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      wb_ack = 1'b0; wb_err = 1'b0;
      if (cw_ack && cw_err) both = 1;
      if (cw_ack) begin
        if (!we) begin
          checks++;
          if (cw_io_o !== rd[acks]) $display("FAIL rd_data: got %0h expected %0h", cw_io_o, rd[acks]);
          else passes++;
        end
        checks++;
        if (wb_cyc !== (acks + 1 < n)) $display("FAIL ack_cyc: got %0b expected %0b", wb_cyc, acks + 1 < n);
        else passes++;
        acks++;
        if (acks < 8) cw_io_i = wd[acks];
        if (acks == exp_acks && exp_errs == 0 && abort_beat < 0) done = 1;
      end
      if (cw_err) begin
        errs++;
        checks++;
        if ({wb_cyc, wb_stb} !== 2'b00) $display("FAIL err_cyc: got %0b expected 00", {wb_cyc, wb_stb});
        else passes++;
        done = 1;
      end
      if (stall > 0) begin
        checks++;
        if (wb_stb !== 1'b0) $display("FAIL stall_stb: got %0b expected 0", wb_stb); else passes++;
        stall--;
        if (stall == 0) cw_dir = we;
      end
      if (wb_stb && !done) begin
        if (!in_beat) begin
          in_beat = 1;
          wait_left = $urandom_range(max_wait, 0);
          exp_adr = (int'(adr) + acks) % (1 << 24);
          checks++;
          if ({wb_adr, wb_we, wb_sel, wb_cyc} !== {24'(exp_adr), we, sel, 1'b1})
            $display("FAIL beat_ctl: got %0h expected %0h", {wb_adr, wb_we, wb_sel, wb_cyc},
                     {24'(exp_adr), we, sel, 1'b1});
          else passes++;
          if (we) begin
            checks++;
            if (wb_o_dat !== wd[acks]) $display("FAIL wr_data: got %0h expected %0h", wb_o_dat, wd[acks]);
            else passes++;
          end
        end
        if (acks == abort_beat) begin
          cw_req = 1'b0; wb_ack = 1'b1; wb_i_dat = rd[acks];
          aborted = 1; done = 1;
        end else if (wait_left == 0) begin
          if (acks == err_beat) wb_err = 1'b1;
          else begin
            wb_ack = 1'b1; wb_i_dat = rd[acks];
          end
          in_beat = 0;
        end else wait_left--;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) $display("FAIL txn_bound: got %0d cycles expected completion", cyc);
    @(negedge clk); wb_ack = 1'b0; wb_err = 1'b0;
    if (aborted) begin
      checks++;
      if ({wb_cyc, wb_stb, cw_ack, cw_err} !== 4'b0000)
        $display("FAIL abort_quiet: got %0b expected 0000", {wb_cyc, wb_stb, cw_ack, cw_err});
      else passes++;
    end else begin
      for (int h = 0; h < 3; h++) begin
        checks++;
        if ({wb_cyc, wb_stb, cw_ack, cw_err} !== 4'b0000)
          $display("FAIL end_hold: got %0b expected 0000", {wb_cyc, wb_stb, cw_ack, cw_err});
        else passes++;
        cw_io_i = 16'($urandom);
        @(negedge clk);
      end
      cw_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({wb_cyc, wb_stb, cw_ack, cw_err} !== 4'b0000)
        $display("FAIL idle_after: got %0b expected 0000", {wb_cyc, wb_stb, cw_ack, cw_err});
      else passes++;
    end
    checks++;
    if (acks !== exp_acks) $display("FAIL ack_count: got %0d expected %0d", acks, exp_acks); else passes++;
    checks++;
    if (errs !== exp_errs) $display("FAIL err_count: got %0d expected %0d", errs, exp_errs); else passes++;
    checks++;
    if (both !== 1'b0) $display("FAIL ack_err_overlap: got %0b expected 0", both); else passes++;
    cw_req = 1'b0; cw_dir = 1'b0;
  endtask

  task automatic test_burst_write_wrap();
    run_txn(24'hFFFFFE, 1'b1, 2'b11, 1'b1, 1'b1, -1, -1, 0, 0, 1'b1);
  endtask

  task automatic test_burst_err();
    run_txn(24'($urandom), 1'b0, 2'b01, 1'b1, 1'b0, 2, -1, 1, 0, 1'b0);
  endtask

  task automatic test_timeout();
    int cnt;
    bit nto_err;
    nto_err = 0;
    @(negedge clk); cw_req = 1'b1; cw_dir = 1'b0; cw_io_i = 16'hA5A5;
    @(negedge clk); cw_io_i = {3'b000, 1'b0, 1'b0, 2'b10, 1'b0, 8'h44};
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wb_stb !== 1'b1) $display("FAIL to_stb_start: got %0b expected 1", wb_stb); else passes++;
    cnt = 0;
    while (!cw_err && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 256) $display("FAIL to_latency: got %0d expected 256", cnt); else passes++;
    checks++;
    if ({wb_cyc, wb_stb} !== 2'b00) $display("FAIL to_cyc: got %0b expected 00", {wb_cyc, wb_stb});
    else passes++;
    for (int i = 0; i < 50; i++) begin
      if (t0_cw_err) nto_err = 1;
      @(negedge clk);
    end
    checks++;
    if ({t0_wb_cyc, t0_wb_stb, nto_err} !== 3'b110)
      $display("FAIL nto_stb_held: got %0b expected 110", {t0_wb_cyc, t0_wb_stb, nto_err});
    else passes++;
    cw_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({t0_wb_cyc, t0_wb_stb, wb_cyc} !== 3'b000)
      $display("FAIL nto_abort: got %0b expected 000", {t0_wb_cyc, t0_wb_stb, wb_cyc});
    else passes++;
  endtask

  task automatic test_abort();
    run_txn(24'h00F0F0, 1'b1, 2'b11, 1'b1, 1'b0, -1, 1, 1, 0, 1'b0);
    run_txn(24'($urandom), 1'b0, 2'b11, 1'b0, 1'b0, -1, -1, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); cw_req = 1'b1; cw_dir = 1'b0; cw_io_i = 16'h7777;
    @(negedge clk); cw_io_i = {3'b000, 1'b0, 1'b0, 2'b11, 1'b1, 8'h55};
    @(negedge clk); cw_io_i = 16'hC0DE; cw_dir = 1'b1;
    for (int i = 0; i < 10 && !wb_stb; i++) @(negedge clk);
    checks++;
    if (wb_stb !== 1'b1) $display("FAIL rm_reach_bus: got %0b expected 1", wb_stb); else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== 63'h0) $display("FAIL rm_outputs: got %0h expected 0", all_out); else passes++;
    rst_n = 1'b1; cw_req = 1'b0; cw_dir = 1'b0;
    @(negedge clk);
    run_txn(24'($urandom), 1'b1, 2'b01, 1'b0, 1'b0, -1, -1, 2, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic we;
    int eb;
    for (int t = 0; t < 24; t++) begin
      we = 1'($urandom);
      eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      run_txn(24'($urandom), we, 2'($urandom), 1'($urandom), 1'($urandom), eb, -1, 3,
              we ? int'($urandom_range(2, 0)) : 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write_wrap();
    test_burst_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
